// File: rtl/calc_sequencer.sv
// Multi-cycle arithmetic controller: one-cycle ADD/SUB, bit-serial shift-add MUL
// and restoring DIV behind a start/busy/done handshake, with a global ena stall.
module calc_sequencer #(
  parameter int unsigned W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ena,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] result,
  output logic           err
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic {
    IDLE,
    EXEC
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  state_e         state_q, state_d;
  op_e            op_q, op_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] mcand_q, mcand_d;   // zero-extended a; shifted left per MUL step
  logic [W-1:0]   opb_q, opb_d;       // b; shifted right per MUL step, divisor for DIV
  logic [W-1:0]   quo_q, quo_d;       // dividend bits out, quotient bits in
  logic [2*W-1:0] acc_q, acc_d;       // product, or remainder in the low W bits
  logic [2*W-1:0] result_q, result_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic [2*W-1:0] add_res, sub_res, mul_sum;
  logic [W:0]     rem_sh;
  logic           rem_ge;
  logic [W-1:0]   rem_nx, quo_nx;
  logic           last;

  assign add_res = mcand_q + {{W{1'b0}}, opb_q};
  assign sub_res = mcand_q - {{W{1'b0}}, opb_q};
  assign mul_sum = acc_q + (opb_q[0] ? mcand_q : '0);
  assign rem_sh  = {acc_q[W-1:0], quo_q[W-1]};
  assign rem_ge  = rem_sh >= {1'b0, opb_q};
  // rem_sh - b is below b whenever it is taken, so it always fits in W bits
  assign rem_nx  = rem_ge ? W'(rem_sh - {1'b0, opb_q}) : rem_sh[W-1:0];
  assign quo_nx  = (quo_q << 1) | W'(rem_ge);
  assign last    = (cnt_q == '0);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    opb_d    = opb_q;
    quo_d    = quo_q;
    acc_d    = acc_q;
    result_d = result_q;
    err_d    = err_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = EXEC;
          op_d    = op_e'(op);
          cnt_d   = CW'(W - 1);
          mcand_d = {{W{1'b0}}, a};
          opb_d   = b;
          quo_d   = a;
          acc_d   = '0;
          err_d   = 1'b0;
        end
      end
      EXEC: begin
        cnt_d = cnt_q - 1'b1;
        unique case (op_q)
          OP_ADD: begin
            state_d  = IDLE;
            done_d   = 1'b1;
            result_d = add_res;
          end
          OP_SUB: begin
            state_d  = IDLE;
            done_d   = 1'b1;
            result_d = sub_res;
          end
          OP_MUL: begin
            acc_d   = mul_sum;
            mcand_d = mcand_q << 1;
            opb_d   = opb_q >> 1;
            if (last) begin
              state_d  = IDLE;
              done_d   = 1'b1;
              result_d = mul_sum;
            end
          end
          OP_DIV: begin
            if (opb_q == '0) begin
              state_d  = IDLE;
              done_d   = 1'b1;
              result_d = '1;
              err_d    = 1'b1;
            end else begin
              acc_d = {{W{1'b0}}, rem_nx};
              quo_d = quo_nx;
              if (last) begin
                state_d  = IDLE;
                done_d   = 1'b1;
                result_d = {rem_nx, quo_nx};
              end
            end
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= OP_ADD;
      cnt_q    <= '0;
      mcand_q  <= '0;
      opb_q    <= '0;
      quo_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (ena) begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      opb_q    <= opb_d;
      quo_q    <= quo_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign busy   = (state_q == EXEC);
  assign done   = done_q;
  assign result = result_q;
  assign err    = err_q;

endmodule
